// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the multiphase clock generator.
// Latency: n/a (types, constants and width helpers only).
// Backpressure: n/a.
package clkgen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } clkState_e;

  // O_S comes out of reset high so the first pulse drives it low.
  localparam logic OS_RESET = 1'b1;

  // Counter width: large enough to hold the longer of pulse and gap length.
  function automatic int cntWidth(input int pulseW, input int gapW);
    int longest;
    longest = (pulseW > gapW) ? pulseW : gapW;
    return $clog2(longest + 1);
  endfunction

  // Phase index width; never below one bit.
  function automatic int idxWidth(input int phases);
    return (phases > 1) ? $clog2(phases) : 1;
  endfunction

endpackage

// File: rtl/clkgen_counter.sv
// Loadable down-counter with terminal-count flag; times both pulse and gap.
// Latency: load takes effect on the next edge; tc is combinational from the count.
// Backpressure: none; counts down every cycle until it reaches zero and holds there.
module clkgen_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             load,
  input  logic [WIDTH-1:0] loadVal,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/multiphase_clock_gen.sv
// Generates PHASES non-overlapping, phase-ordered enables with programmable width and dead time.
// Latency: EN sampled high in IDLE gives PH[0]/SYNC/RUNNING from that same edge (1 cycle).
// Backpressure: none; a stop request drains the current period to its final gap cycle.
// Optional single-period STEP input is enabled by defining CLKGEN_STEP_EN.
module multiphase_clock_gen
  import clkgen_pkg::*;
#(
  parameter int PHASES  = 2,
  parameter int PHASE_W = 1,
  parameter int GAP_W   = 1
) (
  input  logic              CLK,
  input  logic              RST,
`ifdef CLKGEN_STEP_EN
  input  logic              STEP,
`endif
  input  logic              EN,
  output logic [PHASES-1:0] PH,
  output logic              O_S,
  output logic              SYNC,
  output logic              RUNNING
);

  localparam int CNT_W = cntWidth(PHASE_W, GAP_W);
  localparam int IDX_W = idxWidth(PHASES);
  localparam logic [CNT_W-1:0]  PULSE_LOAD = CNT_W'(PHASE_W - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD   = CNT_W'(GAP_W - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(PHASES - 1);
  localparam logic [PHASES-1:0] PH_ONE     = PHASES'(1);

  if (PHASES < 2) begin : gBadPhases
    $error("multiphase_clock_gen: PHASES must be at least 2");
  end
  if (PHASE_W < 1) begin : gBadPulse
    $error("multiphase_clock_gen: PHASE_W must be at least 1");
  end
  if (GAP_W < 1) begin : gBadGap
    $error("multiphase_clock_gen: GAP_W must be at least 1");
  end

  clkState_e         state;
  clkState_e         nextState;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  nextIdx;
  logic              cntLoad;
  logic [CNT_W-1:0]  cntLoadVal;
  logic              cntTc;
  logic              startReq;
  logic              pulseEntry;
  logic [PHASES-1:0] phNext;

  // STEP only matters in IDLE; EN alone decides whether to continue at a boundary,
  // so a STEP-started run naturally ends after one period unless EN rises.
`ifdef CLKGEN_STEP_EN
  assign startReq = EN | STEP;
`else
  assign startReq = EN;
`endif

  clkgen_counter #(
    .WIDTH (CNT_W)
  ) uCounter (
    .clk     (CLK),
    .rstN    (RST),
    .load    (cntLoad),
    .loadVal (cntLoadVal),
    .tc      (cntTc)
  );

  // State and phase-index registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= nextState;
      idx   <= nextIdx;
    end
  end

  // Next-state, phase advance and counter reload; the period boundary is the
  // last gap cycle of the last phase, the only place EN is looked at once running.
  always_comb begin
    nextState  = state;
    nextIdx    = idx;
    cntLoad    = 1'b0;
    cntLoadVal = PULSE_LOAD;
    case (state)
      IDLE: begin
        if (startReq) begin
          nextState  = PULSE;
          nextIdx    = '0;
          cntLoad    = 1'b1;
          cntLoadVal = PULSE_LOAD;
        end
      end
      PULSE: begin
        if (cntTc) begin
          nextState  = GAP;
          cntLoad    = 1'b1;
          cntLoadVal = GAP_LOAD;
        end
      end
      GAP: begin
        if (cntTc) begin
          if (idx == LAST_IDX) begin
            nextIdx = '0;
            if (EN) begin
              nextState  = PULSE;
              cntLoad    = 1'b1;
              cntLoadVal = PULSE_LOAD;
            end else begin
              nextState = IDLE;
            end
          end else begin
            nextState  = PULSE;
            nextIdx    = idx + IDX_W'(1);
            cntLoad    = 1'b1;
            cntLoadVal = PULSE_LOAD;
          end
        end
      end
      default: begin
        nextState = IDLE;
        nextIdx   = '0;
      end
    endcase

    // Gap is at least one cycle, so every PULSE entry is the start of a new phase pulse.
    pulseEntry = (nextState == PULSE) && (state != PULSE);
    phNext     = (nextState == PULSE) ? (PH_ONE << nextIdx) : '0;
  end

  // Outputs registered from next-state so they line up with the state they describe.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      PH      <= '0;
      O_S     <= OS_RESET;
      SYNC    <= 1'b0;
      RUNNING <= 1'b0;
    end else begin
      PH      <= phNext;
      SYNC    <= pulseEntry && (nextIdx == '0);
      RUNNING <= (nextState != IDLE);
      if (pulseEntry) begin
        O_S <= ~O_S;
      end
    end
  end

endmodule

// File: tb/tb_multiphase_clock_gen.sv
// Scoreboard bench: two generators (default and PHASES=4/PHASE_W=3/GAP_W=2) on one clock.
// Stimulus pushes expected per-cycle outputs; a monitor pops and compares every cycle.
// STEP behaviour is exercised only when CLKGEN_STEP_EN is defined.
module tb_multiphase_clock_gen;

  typedef struct packed {
    logic [3:0] ph;
    logic       os;
    logic       sync;
    logic       run;
  } expEntry_t;

  logic clk;
  logic rstA, enA, stepA;
  logic rstB, enB, stepB;
  logic [1:0] phA;
  logic [3:0] phB;
  logic osA, syncA, runA;
  logic osB, syncB, runB;

  expEntry_t qA[$];
  expEntry_t qB[$];
  logic      expOs[2];
  int        errors = 0;
  int        checks = 0;
  int        cyc = 0;

  multiphase_clock_gen dutA (
    .CLK     (clk),
    .RST     (rstA),
`ifdef CLKGEN_STEP_EN
    .STEP    (stepA),
`endif
    .EN      (enA),
    .PH      (phA),
    .O_S     (osA),
    .SYNC    (syncA),
    .RUNNING (runA)
  );

  multiphase_clock_gen #(
    .PHASES  (4),
    .PHASE_W (3),
    .GAP_W   (2)
  ) dutB (
    .CLK     (clk),
    .RST     (rstB),
`ifdef CLKGEN_STEP_EN
    .STEP    (stepB),
`endif
    .EN      (enB),
    .PH      (phB),
    .O_S     (osB),
    .SYNC    (syncB),
    .RUNNING (runB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushEntry(input int d, input expEntry_t e);
    if (d == 0) qA.push_back(e);
    else        qB.push_back(e);
  endtask

  // Expected waveform written straight from the period description:
  // each phase is PW cycles high (SYNC on the first cycle of phase 0), then GW dead cycles.
  task automatic pushPeriods(input int d, input int n);
    int phases, pw, gw;
    logic [3:0] one;
    expEntry_t e;
    one    = 4'b0001;
    phases = (d == 0) ? 2 : 4;
    pw     = (d == 0) ? 1 : 3;
    gw     = (d == 0) ? 1 : 2;
    for (int per = 0; per < n; per++) begin
      for (int p = 0; p < phases; p++) begin
        expOs[d] = ~expOs[d];
        for (int c = 0; c < pw; c++) begin
          e.ph   = one << p;
          e.os   = expOs[d];
          e.sync = (p == 0) && (c == 0);
          e.run  = 1'b1;
          pushEntry(d, e);
        end
        for (int g = 0; g < gw; g++) begin
          e.ph   = 4'b0000;
          e.os   = expOs[d];
          e.sync = 1'b0;
          e.run  = 1'b1;
          pushEntry(d, e);
        end
      end
    end
  endtask

  task automatic pushIdle(input int d, input int n);
    expEntry_t e;
    for (int i = 0; i < n; i++) begin
      e.ph   = 4'b0000;
      e.os   = expOs[d];
      e.sync = 1'b0;
      e.run  = 1'b0;
      pushEntry(d, e);
    end
  endtask

  // Returns on the falling edge where the last expected entry is on the outputs.
  task automatic waitDrain(input int d);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((d == 0 && qA.size() == 0) || (d == 1 && qB.size() == 0)) return;
    end
    checks++;
    errors++;
    $display("FAIL drain timeout dut%0d: %0d entries left, required 0", d,
             (d == 0) ? qA.size() : qB.size());
  endtask

  // Monitor: compares one expected entry per cycle, plus structural checks.
  initial begin
    expEntry_t e;
    logic [6:0] act;
    logic prevB0, prevB2;
    int rise0B, lastSyncB;
    prevB0 = 1'b0;
    prevB2 = 1'b0;
    rise0B = -1;
    lastSyncB = -1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      chk("A onehot0", 32'($onehot0(phA)), 32'd1);
      chk("B onehot0", 32'($onehot0(phB)), 32'd1);
      if (qA.size() > 0) begin
        e   = qA.pop_front();
        act = {2'b00, phA, osA, syncA, runA};
        chk("A outputs {ph,os,sync,run}", 32'(act), 32'(e));
      end
      if (qB.size() > 0) begin
        e   = qB.pop_front();
        act = {phB, osB, syncB, runB};
        chk("B outputs {ph,os,sync,run}", 32'(act), 32'(e));
      end
      if (phB[0] && !prevB0) rise0B = cyc;
      if (phB[2] && !prevB2 && rise0B >= 0) chk("B PH2 rise after PH0", 32'(cyc - rise0B), 32'd10);
      if (syncB) begin
        if (lastSyncB >= 0) chk("B SYNC spacing", 32'(cyc - lastSyncB), 32'd20);
        lastSyncB = cyc;
      end
      prevB0 = phB[0];
      prevB2 = phB[2];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rstA = 1'b0; rstB = 1'b0;
    enA = 1'b1; enB = 1'b0;
    stepA = 1'b0; stepB = 1'b0;
    expOs[0] = 1'b1;
    expOs[1] = 1'b1;

    // Reset state, EN already high
    pushIdle(0, 2);
    pushIdle(1, 2);
    waitDrain(0);

    // Release with EN high: period 4, O_S toggling on each pulse
    rstA = 1'b1;
    rstB = 1'b1;
    pushPeriods(0, 3);
    pushIdle(1, 5);
    waitDrain(0);

    // EN dropped during PH[0]: period completes, then IDLE with O_S held
    pushPeriods(0, 1);
    pushIdle(0, 3);
    @(negedge clk);
    enA = 1'b0;
    waitDrain(0);

    // Stop request withdrawn before the boundary: back-to-back periods
    enA = 1'b1;
    pushPeriods(0, 2);
    @(negedge clk);
    enA = 1'b0;
    @(negedge clk);
    enA = 1'b1;
    waitDrain(0);

    // Asynchronous reset while PH[1] is high
    pushPeriods(0, 1);
    repeat (3) @(negedge clk);
    chk("A PH1 high before reset", 32'(phA), 32'h2);
    qA.delete();
    #2 rstA = 1'b0;
    #1;
    chk("A async reset PH", 32'(phA), 32'h0);
    chk("A async reset O_S", 32'(osA), 32'h1);
    chk("A async reset SYNC", 32'(syncA), 32'h0);
    chk("A async reset RUNNING", 32'(runA), 32'h0);
    expOs[0] = 1'b1;
    pushIdle(0, 2);
    waitDrain(0);

    // Restart after reset begins at PH[0]
    rstA = 1'b1;
    pushPeriods(0, 1);
    pushIdle(0, 2);
    @(negedge clk);
    enA = 1'b0;
    waitDrain(0);

`ifdef CLKGEN_STEP_EN
    // Single step from IDLE; a STEP while running is ignored
    stepA = 1'b1;
    pushPeriods(0, 1);
    pushIdle(0, 3);
    @(negedge clk);
    stepA = 1'b0;
    @(negedge clk);
    stepA = 1'b1;
    @(negedge clk);
    stepA = 1'b0;
    waitDrain(0);
`endif

    // Four phases, width 3, gap 2: period 20, stop requested mid second period
    enB = 1'b1;
    pushPeriods(1, 2);
    pushIdle(1, 3);
    repeat (25) @(negedge clk);
    enB = 1'b0;
    waitDrain(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
